// File: rtl/tile_pixel_reader_pkg.sv
// Shared tile geometry, colour defaults and FSM state type for the tile pixel reader.
package tile_pixel_reader_pkg;

  localparam int TW_LOG2_DEF  = 3;
  localparam int TH_LOG2_DEF  = 3;
  localparam int IDX_W_DEF    = 5;
  localparam int X_W_DEF      = 8;
  localparam int Y_W_DEF      = 7;
  localparam int COLOUR_W_DEF = 3;
  localparam logic [COLOUR_W_DEF-1:0] TRANSP_COL_DEF = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_t;

  function automatic logic is_busy(input state_t s);
    return (s == ST_READ) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/tile_pixel_reader_if.sv
// Bundle of draw handshake, tile ROM port and plot port for the tile pixel reader.
interface tile_pixel_reader_if
  import tile_pixel_reader_pkg::*;
#(
  parameter int TW_LOG2  = TW_LOG2_DEF,
  parameter int TH_LOG2  = TH_LOG2_DEF,
  parameter int IDX_W    = IDX_W_DEF,
  parameter int X_W      = X_W_DEF,
  parameter int Y_W      = Y_W_DEF,
  parameter int COLOUR_W = COLOUR_W_DEF
);

  localparam int ADDR_W = IDX_W + TW_LOG2 + TH_LOG2;

  logic                start;
  logic [IDX_W-1:0]    tile_idx;
  logic [X_W-1:0]      x0;
  logic [Y_W-1:0]      y0;
  logic                busy;
  logic                done;
  logic [ADDR_W-1:0]   rom_addr;
  logic [COLOUR_W-1:0] rom_data;
  logic [X_W-1:0]      plot_x;
  logic [Y_W-1:0]      plot_y;
  logic [COLOUR_W-1:0] plot_colour;
  logic                plot;

  // master: draw controller plus tile ROM; slave: the reader itself
  modport master (
    output start, tile_idx, x0, y0, rom_data,
    input  busy, done, rom_addr, plot_x, plot_y, plot_colour, plot
  );

  modport slave (
    input  start, tile_idx, x0, y0, rom_data,
    output busy, done, rom_addr, plot_x, plot_y, plot_colour, plot
  );

endinterface

// File: rtl/tile_pixel_reader_scan_counter.sv
// Row-major column/row scan counter over one tile, with clear, enable and last-pixel flag.
module tile_scan_counter #(
  parameter int TW_LOG2 = 3,
  parameter int TH_LOG2 = 3
) (
  input  logic               Clock,
  input  logic               Resetn,
  input  logic               clear,
  input  logic               en,
  output logic [TW_LOG2-1:0] col,
  output logic [TH_LOG2-1:0] row,
  output logic               last
);

  always_ff @(posedge Clock) begin
    if (!Resetn || clear) begin
      col <= '0;
      row <= '0;
    end else if (en) begin
      if (col == '1) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign last = (&col) && (&row);

endmodule

// File: rtl/tile_pixel_reader.sv
// Streams one tile from a synchronous tile ROM to the plot port in row-major order,
// optionally skipping the transparent colour.
module tile_pixel_reader
  import tile_pixel_reader_pkg::*;
#(
  parameter int TW_LOG2  = TW_LOG2_DEF,
  parameter int TH_LOG2  = TH_LOG2_DEF,
  parameter int IDX_W    = IDX_W_DEF,
  parameter int X_W      = X_W_DEF,
  parameter int Y_W      = Y_W_DEF,
  parameter int COLOUR_W = COLOUR_W_DEF,
  parameter bit TRANSP_EN = 1'b1,
  parameter logic [COLOUR_W-1:0] TRANSP_COL = TRANSP_COL_DEF
) (
  input logic               Clock,
  input logic               Resetn,
  tile_pixel_reader_if.slave bus
);

  state_t state, state_n;

  logic [IDX_W-1:0]    tile_q;
  logic [X_W-1:0]      x0_q;
  logic [Y_W-1:0]      y0_q;

  logic [TW_LOG2-1:0]  col;
  logic [TH_LOG2-1:0]  row;
  logic                last;
  logic                accept;
  logic                scan_en;

  logic                valid_d;
  logic [X_W-1:0]      px_d;
  logic [Y_W-1:0]      py_d;

  logic [X_W-1:0]      last_x;
  logic [Y_W-1:0]      last_y;
  logic [COLOUR_W-1:0] last_col;
  logic                plot_i;

  assign accept = (state == ST_IDLE) && bus.start;
  // Counter freezes on the last pixel so rom_addr keeps the last issued address.
  assign scan_en = (state == ST_READ) && !last;

  tile_scan_counter #(
    .TW_LOG2 (TW_LOG2),
    .TH_LOG2 (TH_LOG2)
  ) u_scan (
    .Clock  (Clock),
    .Resetn (Resetn),
    .clear  (accept),
    .en     (scan_en),
    .col    (col),
    .row    (row),
    .last   (last)
  );

  always_ff @(posedge Clock) begin
    if (!Resetn) state <= ST_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:  if (bus.start) state_n = ST_READ;
      ST_READ:  if (last)      state_n = ST_DRAIN;
      ST_DRAIN:                state_n = ST_DONE;
      ST_DONE:                 state_n = ST_IDLE;
      default:                 state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      tile_q <= '0;
      x0_q   <= '0;
      y0_q   <= '0;
    end else if (accept) begin
      tile_q <= bus.tile_idx;
      x0_q   <= bus.x0;
      y0_q   <= bus.y0;
    end
  end

  // Coordinates ride one cycle behind the address to meet the ROM data.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      valid_d <= 1'b0;
      px_d    <= '0;
      py_d    <= '0;
    end else begin
      valid_d <= (state == ST_READ);
      px_d    <= x0_q + X_W'(col);
      py_d    <= y0_q + Y_W'(row);
    end
  end

  assign plot_i = valid_d && !(TRANSP_EN && (bus.rom_data == TRANSP_COL));

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      last_x   <= '0;
      last_y   <= '0;
      last_col <= '0;
    end else if (plot_i) begin
      last_x   <= px_d;
      last_y   <= py_d;
      last_col <= bus.rom_data;
    end
  end

  assign bus.rom_addr    = {tile_q, row, col};
  assign bus.busy        = is_busy(state);
  assign bus.done        = (state == ST_DONE);
  assign bus.plot        = plot_i;
  assign bus.plot_x      = plot_i ? px_d : last_x;
  assign bus.plot_y      = plot_i ? py_d : last_y;
  assign bus.plot_colour = plot_i ? bus.rom_data : last_col;

endmodule

// File: tb/tb_tile_pixel_reader.sv
// Directed bench for tile_pixel_reader with a behavioural synchronous tile ROM.
module tb_tile_pixel_reader;

  logic Clock;
  logic Resetn;

  tile_pixel_reader_if bus ();

  tile_pixel_reader dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  logic [2:0] mem [0:2047];

  int n_checks = 0;
  int n_fail   = 0;
  int last_x   = 0;
  int last_y   = 0;
  int last_c   = 0;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) bus.rom_data <= mem[bus.rom_addr];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic run_tile(input int idx, input int x0v, input int y0v, input int glitch);
    int exp_plot, act_plot, k, ex, ey;
    logic [2:0] pc;
    logic ep;
    exp_plot = 0;
    act_plot = 0;
    for (int i = 0; i < 64; i++) if (mem[idx*64+i] != 3'b000) exp_plot++;
    @(negedge Clock);
    bus.start    = 1'b1;
    bus.tile_idx = 5'(idx);
    bus.x0       = 8'(x0v);
    bus.y0       = 7'(y0v);
    @(posedge Clock);
    #1 bus.start = 1'b0;
    for (int c = 1; c <= 70; c++) begin
      @(negedge Clock);
      if (glitch != 0 && c == glitch) begin
        bus.start    = 1'b1;
        bus.tile_idx = 5'd7;
        bus.x0       = 8'd99;
        bus.y0       = 7'd99;
      end else begin
        bus.start = 1'b0;
      end
      check_eq("busy", 32'(bus.busy), (c <= 65) ? 32'd1 : 32'd0);
      check_eq("done", 32'(bus.done), (c == 66) ? 32'd1 : 32'd0);
      if (c <= 64) check_eq("rom_addr", 32'(bus.rom_addr), 32'(idx*64 + c - 1));
      else         check_eq("rom_addr_hold", 32'(bus.rom_addr), 32'(idx*64 + 63));
      ep = 1'b0;
      k  = 0;
      pc = 3'b000;
      if (c >= 2 && c <= 65) begin
        k  = c - 2;
        pc = mem[idx*64+k];
        ep = (pc != 3'b000);
      end
      if (bus.plot) act_plot++;
      check_eq("plot", 32'(bus.plot), 32'(ep));
      if (ep) begin
        ex = (x0v + k % 8) % 256;
        ey = (y0v + k / 8) % 128;
        check_eq("plot_x", 32'(bus.plot_x), 32'(ex));
        check_eq("plot_y", 32'(bus.plot_y), 32'(ey));
        check_eq("plot_colour", 32'(bus.plot_colour), 32'(pc));
        last_x = ex;
        last_y = ey;
        last_c = int'(pc);
      end else begin
        check_eq("hold_x", 32'(bus.plot_x), 32'(last_x));
        check_eq("hold_y", 32'(bus.plot_y), 32'(last_y));
        check_eq("hold_colour", 32'(bus.plot_colour), 32'(last_c));
      end
    end
    check_eq("plot_count", 32'(act_plot), 32'(exp_plot));
  endtask

  initial begin
    for (int t = 0; t < 32; t++) begin
      for (int k = 0; k < 64; k++) begin
        case (t)
          1:       mem[t*64+k] = 3'(1 + k % 7);
          2:       mem[t*64+k] = (((k % 8) ^ (k / 8)) & 1) != 0 ? 3'b111 : 3'b000;
          3:       mem[t*64+k] = 3'b101;
          4:       mem[t*64+k] = 3'b010;
          5:       mem[t*64+k] = 3'b110;
          default: mem[t*64+k] = 3'b011;
        endcase
      end
    end

    Resetn       = 1'b0;
    bus.start    = 1'b0;
    bus.tile_idx = '0;
    bus.x0       = '0;
    bus.y0       = '0;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    Resetn = 1'b1;
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_done", 32'(bus.done), 32'd0);
    check_eq("rst_plot", 32'(bus.plot), 32'd0);
    check_eq("rst_addr", 32'(bus.rom_addr), 32'd0);
    check_eq("rst_plot_x", 32'(bus.plot_x), 32'd0);

    // Reset asserted for two edges in the middle of a tile.
    @(negedge Clock);
    bus.start    = 1'b1;
    bus.tile_idx = 5'd3;
    bus.x0       = 8'd10;
    bus.y0       = 7'd20;
    @(posedge Clock);
    #1 bus.start = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge Clock);
      if (c == 20) Resetn = 1'b0;
      if (c == 22) Resetn = 1'b1;
      if (c == 10) check_eq("mid_busy", 32'(bus.busy), 32'd1);
      if (c >= 21) begin
        check_eq("rstm_busy", 32'(bus.busy), 32'd0);
        check_eq("rstm_done", 32'(bus.done), 32'd0);
        check_eq("rstm_plot", 32'(bus.plot), 32'd0);
      end
      if (c == 21 || c == 22) check_eq("rstm_addr", 32'(bus.rom_addr), 32'd0);
    end
    last_x = 0;
    last_y = 0;
    last_c = 0;

    run_tile(3, 10, 20, 0);
    run_tile(1, 0, 0, 0);
    run_tile(2, 30, 40, 0);
    run_tile(4, 252, 125, 0);
    run_tile(5, 40, 50, 30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
